and_stim_driver: RTL and testbench

Synthesizable stimulus-and-check engine for a 2-input AND datapath. It sequences the four input vectors {a,b} = 00, 01, 10, 11 into the DUT and holds each for a programmable number of cycles. It samples the DUT output `y` at the end of each hold window, compares it with the expected `a&b`, and counts mismatches. A per-vector trace-enable window (`mon_en`) gates an external logger on and off, which gives hardware the same on/off monitoring control the simulation benches use.

---
 rtl/and_stim_driver.sv | 127 ++++++++++++
 tb/tb_and_stim_driver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/and_stim_driver.sv
// and_stim_driver: drives the four {a,b} vectors into a 2-input AND datapath,
// holds each for HOLD_CYCLES cycles, samples y at the end of each hold window,
// counts mismatches and gates an external trace logger through mon_en.
module and_stim_driver #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] mon_mask,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       mon_en,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic [2:0] err_cnt,
  output logic       pass
);

  localparam int CW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    mask_q;

  logic          mismatch;
  logic [2:0]    err_next;
  logic [1:0]    idx_next;

  // Saturating increment; 7 can never be reached with four samples per run.
  function automatic logic [2:0] sat_inc(input logic [2:0] val, input logic inc);
    logic [2:0] res;
    if (inc && (val != 3'd7)) begin
      res = val + 3'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

  // Sample-edge helpers: compare y against the currently driven vector.
  always_comb begin
    mismatch = 1'b0;
    err_next = err_cnt;
    idx_next = vec_idx + 2'd1;
    if (y != (a & b)) begin
      mismatch = 1'b1;
    end else begin
      mismatch = 1'b0;
    end
    err_next = sat_inc(err_cnt, mismatch);
  end

  // Run sequencer: IDLE/RUN state, hold counter, vector stepping and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      mask_q  <= 4'd0;
      a       <= 1'b0;
      b       <= 1'b0;
      mon_en  <= 1'b0;
      vec_idx <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err_cnt <= 3'd0;
      pass    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            vec_idx <= 2'd0;
            a       <= 1'b0;
            b       <= 1'b0;
            cnt     <= '0;
            err_cnt <= 3'd0;
            pass    <= 1'b0;
            mask_q  <= mon_mask;
            busy    <= 1'b1;
            mon_en  <= mon_mask[0];
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (cnt < LAST) begin
            cnt <= cnt + CW'(1);
          end else begin
            err_cnt <= err_next;
            if (vec_idx != 2'd3) begin
              vec_idx <= idx_next;
              a       <= idx_next[1];
              b       <= idx_next[0];
              cnt     <= '0;
              mon_en  <= mask_q[idx_next];
            end else begin
              // Last vector sampled: close the run; pass includes this sample.
              state   <= IDLE;
              done    <= 1'b1;
              busy    <= 1'b0;
              mon_en  <= 1'b0;
              a       <= 1'b0;
              b       <= 1'b0;
              vec_idx <= 2'd0;
              cnt     <= '0;
              pass    <= (err_next == 3'd0);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and_stim_driver.sv
// Directed bench for and_stim_driver: table of full runs on an H=10 instance
// plus hand sequences for restart, mid-run reset and an H=1 instance.
module tb_and_stim_driver;

  localparam int H = 10;

  logic       clk;
  logic       rst_n;

  logic       start10, y10, a10, b10, mon10, busy10, done10, pass10;
  logic [3:0] mask10;
  logic [1:0] vec10;
  logic [2:0] err10;
  logic [1:0] mode10;

  logic       start1, y1, a1, b1, mon1, busy1, done1, pass1;
  logic [3:0] mask1;
  logic [1:0] vec1;
  logic [2:0] err1;
  logic [1:0] mode1;

  int checks = 0;
  int errors = 0;

  and_stim_driver #(.HOLD_CYCLES(H)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .mon_mask(mask10), .y(y10),
    .a(a10), .b(b10), .mon_en(mon10), .vec_idx(vec10), .busy(busy10),
    .done(done10), .err_cnt(err10), .pass(pass10)
  );

  and_stim_driver #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mon_mask(mask1), .y(y1),
    .a(a1), .b(b1), .mon_en(mon1), .vec_idx(vec1), .busy(busy1),
    .done(done1), .err_cnt(err1), .pass(pass1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath under test: 0 = AND, 1 = OR, 2 = stuck-at-0, 3 = stuck-at-1.
  function automatic logic dp(input logic [1:0] mode, input logic x0, input logic x1);
    case (mode)
      2'd0:    return x0 & x1;
      2'd1:    return x0 | x1;
      2'd2:    return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign y10 = dp(mode10, a10, b10);
  assign y1  = dp(mode1, a1, b1);

  // Mismatches counted among vectors 0..k-1.
  function automatic logic [2:0] errs_before(input logic [3:0] mism, input int k);
    logic [2:0] c = 3'd0;
    for (int i = 0; i < k; i++) if (mism[i]) c = c + 3'd1;
    return c;
  endfunction

  // Packed observation: {a,b,vec_idx,busy,done,mon_en,err_cnt,pass}.
  function automatic logic [10:0] obs10();
    return {a10, b10, vec10, busy10, done10, mon10, err10, pass10};
  endfunction
  function automatic logic [10:0] obs1();
    return {a1, b1, vec1, busy1, done1, mon1, err1, pass1};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (a,b,vec,busy,done,mon,err,pass) t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Called at a negedge; start is seen by the next posedge (edge N).
  task automatic launch10(input logic [3:0] mask);
    start10 = 1'b1;
    mask10  = mask;
    @(negedge clk);
    start10 = 1'b0;
  endtask

  // Checks every cycle after edge N for 'cycles' cycles; with cycles==4H also checks done.
  task automatic follow10(input logic [3:0] mask, input logic [3:0] mism, input int restart_at,
                          input int cycles, input logic [2:0] exp_err, input logic exp_pass);
    for (int j = 0; j < cycles; j++) begin
      logic [1:0] k2;
      k2 = 2'(j / H);
      check($sformatf("run10 cyc%0d", j), obs10(),
            {k2[1], k2[0], k2, 1'b1, 1'b0, mask[k2], errs_before(mism, j / H), 1'b0});
      start10 = (j == restart_at);
      @(negedge clk);
    end
    start10 = 1'b0;
    if (cycles == 4 * H) begin
      check("run10 done", obs10(), {1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, exp_err, exp_pass});
    end
  endtask

  task automatic hold10(input logic [2:0] exp_err, input logic exp_pass);
    repeat (3) @(negedge clk);
    check("idle hold", obs10(), {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, exp_err, exp_pass});
  endtask

  task automatic run1(input logic [3:0] mask, input logic [3:0] mism,
                      input logic [2:0] exp_err, input logic exp_pass);
    start1 = 1'b1;
    mask1  = mask;
    @(negedge clk);
    start1 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      logic [1:0] k2;
      k2 = 2'(j);
      check($sformatf("run1 cyc%0d", j), obs1(),
            {k2[1], k2[0], k2, 1'b1, 1'b0, mask[k2], errs_before(mism, j), 1'b0});
      @(negedge clk);
    end
    check("run1 done", obs1(), {1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, exp_err, exp_pass});
    @(negedge clk);
    check("run1 idle", obs1(), {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, exp_err, exp_pass});
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [1:0] mode;
    logic [3:0] mism;
    logic [2:0] exp_err;
    logic       exp_pass;
  } run_vec_t;

  run_vec_t tbl[5];

  initial begin
    tbl[0] = '{4'b1111, 2'd0, 4'b0000, 3'd0, 1'b1};
    tbl[1] = '{4'b1001, 2'd0, 4'b0000, 3'd0, 1'b1};
    tbl[2] = '{4'b0110, 2'd1, 4'b0110, 3'd2, 1'b0};
    tbl[3] = '{4'b0000, 2'd2, 4'b1000, 3'd1, 1'b0};
    tbl[4] = '{4'b0101, 2'd3, 4'b0111, 3'd3, 1'b0};

    rst_n = 1'b0; start10 = 1'b0; start1 = 1'b0;
    mask10 = 4'd0; mask1 = 4'd0; mode10 = 2'd0; mode1 = 2'd0;
    repeat (2) @(negedge clk);
    check("reset10", obs10(), 11'd0);
    check("reset1", obs1(), 11'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after reset", obs10(), 11'd0);

    // Table of full runs on the H=10 instance.
    for (int t = 0; t < 5; t++) begin
      mode10 = tbl[t].mode;
      launch10(tbl[t].mask);
      follow10(tbl[t].mask, tbl[t].mism, -1, 4 * H, tbl[t].exp_err, tbl[t].exp_pass);
      hold10(tbl[t].exp_err, tbl[t].exp_pass);
    end

    // Start re-pulsed at run cycle 5 is ignored; then start during done restarts.
    mode10 = 2'd1;
    launch10(4'b1111);
    follow10(4'b1111, 4'b0110, 5, 4 * H, 3'd2, 1'b0);
    mode10 = 2'd0;
    launch10(4'b0011);
    follow10(4'b0011, 4'b0000, -1, 4 * H, 3'd0, 1'b1);
    hold10(3'd0, 1'b1);

    // Reset at run cycle 15: everything drops asynchronously, no done.
    launch10(4'b1111);
    follow10(4'b1111, 4'b0000, -1, 15, 3'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async reset midrun", obs10(), 11'd0);
    @(negedge clk);
    check("in reset", obs10(), 11'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("after reset release", obs10(), 11'd0);
    @(negedge clk);
    check("no done after reset", obs10(), 11'd0);
    launch10(4'b1111);
    follow10(4'b1111, 4'b0000, -1, 4 * H, 3'd0, 1'b1);
    hold10(3'd0, 1'b1);

    // H=1 instance: one cycle per vector.
    mode1 = 2'd0;
    run1(4'b1010, 4'b0000, 3'd0, 1'b1);
    mode1 = 2'd2;
    run1(4'b0110, 4'b1000, 3'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
